// File: rtl/riscv_pkg.sv
// Shared types and sizing helpers for the external-memory arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_RESP
  } arb_state_t;

  // Channel index width; kept at least 1 bit so a single-channel build still has a legal vector.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/riscv_rr_picker.sv
// Round-robin picker: first requesting channel strictly after last_grant, wrapping at NUM_CH.
module riscv_rr_picker
  import riscv_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// N-channel round-robin arbiter sharing one external memory port, with ack timeout.
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     ext_mem_en,
  output logic                     ext_we,
  output logic [ADDR_W-1:0]        ext_addr,
  output logic [DATA_W-1:0]        ext_data_out,
  input  logic [DATA_W-1:0]        ext_data_in,
  input  logic                     ext_ack
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_t        state_reg;
  logic [CH_W-1:0]   last_grant_reg;
  logic [CH_W-1:0]   id_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [NUM_CH-1:0] pick_grant;
  logic [CH_W-1:0]   pick_idx;

  riscv_rr_picker #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_picker (
    .req       (req_valid),
    .last_grant(last_grant_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign req_ready = (state_reg == ARB_IDLE) ? pick_grant : '0;

  // The ext_* registers double as the request latches; they are only non-zero while in BUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= CH_W'(NUM_CH - 1);
      id_reg         <= '0;
      cnt_reg        <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      ext_mem_en     <= 1'b0;
      ext_we         <= 1'b0;
      ext_addr       <= '0;
      ext_data_out   <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (|(req_valid & req_ready)) begin
            id_reg       <= pick_idx;
            ext_mem_en   <= 1'b1;
            ext_we       <= req_we[pick_idx];
            ext_addr     <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            ext_data_out <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            cnt_reg      <= '0;
            state_reg    <= ARB_BUS;
          end
        end
        ARB_BUS: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (ext_ack || cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // An ack in the timeout cycle still counts as a normal completion.
            rsp_valid    <= NUM_CH'(1) << id_reg;
            rsp_rdata    <= (ext_ack && !ext_we) ? ext_data_in : '0;
            rsp_err      <= !ext_ack;
            ext_mem_en   <= 1'b0;
            ext_we       <= 1'b0;
            ext_addr     <= '0;
            ext_data_out <= '0;
            state_reg    <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          rsp_valid      <= '0;
          rsp_rdata      <= '0;
          rsp_err        <= 1'b0;
          last_grant_reg <= id_reg;
          cnt_reg        <= '0;
          state_reg      <= ARB_IDLE;
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule
